sram_port_ctrl: RTL

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

---
 rtl/sram_port_pkg.sv | 17 +
 rtl/sram_port_resp_fifo.sv | 60 ++++++
 rtl/sram_port_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/sram_port_pkg.sv
// Shared defaults and types for the SRAM RW0 port controller.
// Build option: define SRAM_PORT_INIT_EN to zero-fill the SRAM after reset.
package sram_port_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_LANES  = 4;
  localparam int RESP_DEPTH = 3;

  // ST_INIT: zero-fill sweep (or just the reset window when the sweep is
  // compiled out). ST_RUN: requests are served.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_port_state_e;

endpackage

// File: rtl/sram_port_resp_fifo.sv
// Small response buffer for read data. Output data comes straight from the
// storage registers, so resp_valid/resp_data never depend on pop_i.
module sram_port_resp_fifo
  import sram_port_pkg::*;
#(
  parameter int DEPTH = RESP_DEPTH,
  parameter int W     = DEF_DATA_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output logic [W-1:0]                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop;

  // A pop is only honoured while something is buffered.
  assign pop = pop_i && (count_q != '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Storage: data needs no reset, occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Request/response front end for a single-port (RW0) SRAM with 1-cycle read
// latency. Build option: SRAM_PORT_INIT_EN adds a zero-fill sweep after reset.
//
// Handshake: a transfer happens on a channel in a cycle where valid and ready
// are both high; valid never waits for ready, and req_ready is computed from
// registered state plus req_write only (never from resp_ready).
module sram_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LANES-1:0]  req_mask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [LANES-1:0]  sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done,
  output sram_port_state_e  state_o
);

  localparam int CW = $clog2(RESP_DEPTH+1);
  localparam int SW = CW + 1;

  sram_port_state_e state_q;
  logic             inflight_q;
  logic [CW-1:0]    occ;
  logic             run, read_ok, req_fire, read_fire;

  assign run       = (state_q == ST_RUN);
  // Reads are admitted only while a FIFO slot is guaranteed for their data.
  assign read_ok   = (({1'b0, occ} + SW'(inflight_q)) < SW'(RESP_DEPTH));
  assign req_ready = run && (req_write || read_ok);
  assign req_fire  = req_valid && req_ready;
  assign read_fire = req_fire && !req_write;

`ifdef SRAM_PORT_INIT_EN
  logic [ADDR_W-1:0] init_addr_q;

  // Controller FSM: sweep every address once with zero data, then serve.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else if (state_q == ST_INIT) begin
      if (init_addr_q == '1) state_q <= ST_RUN;
      else                   init_addr_q <= init_addr_q + 1'b1;
    end
  end
`else
  // Controller FSM: INIT only spans the reset window, RUN from the first edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= ST_RUN;
  end
`endif

  // Read tracking: sram_rdata is valid exactly one cycle after a read fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= read_fire;
  end

  // SRAM port drive: requests pass straight through; the sweep overrides.
  always_comb begin
    sram_en    = req_fire;
    sram_wmode = req_write;
    sram_addr  = req_addr;
    sram_wmask = req_mask;
    sram_wdata = req_wdata;
`ifdef SRAM_PORT_INIT_EN
    if (state_q == ST_INIT) begin
      // Qualified by reset so the port is quiet the instant reset asserts.
      sram_en    = !reset;
      sram_wmode = 1'b1;
      sram_addr  = init_addr_q;
      sram_wmask = '1;
      sram_wdata = '0;
    end
`endif
  end

  sram_port_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (DATA_W)
  ) u_resp_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (inflight_q),
    .data_i  (sram_rdata),
    .pop_i   (resp_ready),
    .valid_o (resp_valid),
    .data_o  (resp_data),
    .count_o (occ)
  );

  assign init_done = run;
  assign state_o   = state_q;

endmodule
